// File: rtl/cpu_sram_responder.sv
// cpu_sram_responder
//   Target side of the core's inst_sram_* / data_sram_* interfaces. Both ports
//   share one word RAM. The data port can also reach a small MMIO page that
//   holds the LED, 7-segment number, switch readback and a compare timer.
//   Both ports have a fixed one-cycle read latency. Reads return the word as it
//   was before the edge, so a write returns the old word.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   inst_sram_*         instruction port (read-only; wen/wdata ignored)
//   data_sram_*         data port, byte-lane writes through wen[3:0]
//   switch              raw board switches (asynchronous, synchronised here)
//   led                 LED register (16 bits)
//   num_data            7-segment number register
//   timer_int           level interrupt, equal to the timer PEND bit
//
// Handshake: there is no valid/ready. A request is the en signal high at a
// rising edge. The matching rdata is valid right after that edge and holds
// until the next accepted request or reset.
module cpu_sram_responder #(
    parameter int          MEM_AW    = 14,
    parameter              INIT_FILE = "",
    parameter logic [15:0] MMIO_HI   = 16'hBFAF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_wen,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [7:0]  switch,
    output logic [15:0] led,
    output logic [31:0] num_data,
    output logic        timer_int
);

    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_NUM   = 16'hF010;
    localparam logic [15:0] OFF_SW    = 16'hF020;
    localparam logic [15:0] OFF_TIMER = 16'hE000;
    localparam logic [15:0] OFF_CMP   = 16'hE004;
    localparam logic [15:0] OFF_CTRL  = 16'hE008;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_word[8*i +: 8];
        end
        return r;
    endfunction

    logic [31:0] mem [0:(1 << MEM_AW) - 1];

    logic [MEM_AW-1:0] inst_idx;
    logic [MEM_AW-1:0] data_idx;
    logic              inst_mmio;
    logic              data_mmio;
    logic              data_wr;
    logic              ram_wr;
    logic              mmio_wr;
    logic [15:0]       off;

    // Upper address bits above the RAM index alias onto the same words.
    assign inst_idx  = inst_sram_addr[MEM_AW+1:2];
    assign data_idx  = data_sram_addr[MEM_AW+1:2];
    assign inst_mmio = (inst_sram_addr[31:16] == MMIO_HI);
    assign data_mmio = (data_sram_addr[31:16] == MMIO_HI);
    assign data_wr   = data_sram_en && (data_sram_wen != 4'b0000);
    assign ram_wr    = data_wr && !data_mmio;
    assign mmio_wr   = data_wr && data_mmio;
    assign off       = {data_sram_addr[15:2], 2'b00};

    // MMIO state
    logic [31:0] timer_cnt;
    logic [31:0] cmp;
    logic        tmr_en;
    logic        pend;
    logic        match_q;
    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;

    logic wr_led, wr_num, wr_timer, wr_cmp, wr_ctrl;
    assign wr_led   = mmio_wr && (off == OFF_LED);
    assign wr_num   = mmio_wr && (off == OFF_NUM);
    assign wr_timer = mmio_wr && (off == OFF_TIMER);
    assign wr_cmp   = mmio_wr && (off == OFF_CMP);
    assign wr_ctrl  = mmio_wr && (off == OFF_CTRL);

    logic [31:0] led_wr_val, num_wr_val, timer_wr_val, cmp_wr_val;
    assign led_wr_val   = lane_merge({16'h0000, led}, data_sram_wdata, data_sram_wen);
    assign num_wr_val   = lane_merge(num_data, data_sram_wdata, data_sram_wen);
    assign timer_wr_val = lane_merge(timer_cnt, data_sram_wdata, data_sram_wen);
    assign cmp_wr_val   = lane_merge(cmp, data_sram_wdata, data_sram_wen);

    // MMIO read mux. It gives the register values from before the edge.
    logic [31:0] mmio_rd;
    always_comb begin
        mmio_rd = 32'h0;
        case (off)
            OFF_LED:   mmio_rd = {16'h0000, led};
            OFF_NUM:   mmio_rd = num_data;
            OFF_SW:    mmio_rd = {24'h0, sw_sync};
            OFF_TIMER: mmio_rd = timer_cnt;
            OFF_CMP:   mmio_rd = cmp;
            OFF_CTRL:  mmio_rd = {30'h0, pend, tmr_en};
            default:   mmio_rd = 32'h0;
        endcase
    end

    // RAM array. It has no reset, so its contents survive rst.
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[data_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    // Read registers. The non-blocking reads see the word from before any
    // same-edge write, on both ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
        end else begin
            if (inst_sram_en) inst_sram_rdata <= inst_mmio ? 32'h0 : mem[inst_idx];
            if (data_sram_en) data_sram_rdata <= data_mmio ? mmio_rd : mem[data_idx];
        end
    end

    // MMIO registers, timer and switch synchroniser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led       <= 16'h0;
            num_data  <= 32'h0;
            timer_cnt <= 32'h0;
            cmp       <= 32'hFFFF_FFFF;
            tmr_en    <= 1'b0;
            pend      <= 1'b0;
            match_q   <= 1'b0;
            sw_meta   <= 8'h0;
            sw_sync   <= 8'h0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;

            if (wr_led) led <= led_wr_val[15:0];
            if (wr_num) num_data <= num_wr_val;
            if (wr_cmp) cmp <= cmp_wr_val;

            // A CPU write to the counter takes priority over the increment.
            if (wr_timer)    timer_cnt <= timer_wr_val;
            else if (tmr_en) timer_cnt <= timer_cnt + 32'd1;

            // A match seen at this edge raises PEND one edge later.
            match_q <= tmr_en && (timer_cnt == cmp);

            if (wr_ctrl && data_sram_wen[0]) tmr_en <= data_sram_wdata[0];

            // A hardware set takes priority over a W1C clear on the same edge.
            if (match_q)                                            pend <= 1'b1;
            else if (wr_ctrl && data_sram_wen[0] && data_sram_wdata[1]) pend <= 1'b0;
        end
    end

    assign timer_int = pend;

    logic unused_ok;
    assign unused_ok = ^{inst_sram_wen, inst_sram_wdata, inst_sram_addr,
                         data_sram_addr, led_wr_val[31:16]};

endmodule

// File: tb/tb_cpu_sram_responder.sv
// tb_cpu_sram_responder
//   Self-checking bench for cpu_sram_responder. Directed scenarios are mixed
//   with a randomized dual-port RAM exercise. The reference is a sparse word
//   map indexed by word address, plus plain variables for the MMIO page.
module tb_cpu_sram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [7:0]  switch;
    logic [15:0] led;
    logic [31:0] num_data;
    logic        timer_int;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ref_mem [int];

    cpu_sram_responder dut (
        .clk(clk), .rst(rst),
        .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata),
        .switch(switch), .led(led), .num_data(num_data), .timer_int(timer_int)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // driver tasks
    task automatic data_op(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        data_sram_en    = 1'b1;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        tick();
        data_sram_en  = 1'b0;
        data_sram_wen = 4'b0000;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    task automatic test_reset();
        tick();
        tick();
        checks++; if (inst_sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_inst_rdata got=%h exp=0", inst_sram_rdata); end
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_data_rdata got=%h exp=0", data_sram_rdata); end
        checks++; if (led !== 16'h0) begin failures++; $display("FAIL reset_led got=%h exp=0", led); end
        checks++; if (num_data !== 32'h0) begin failures++; $display("FAIL reset_num got=%h exp=0", num_data); end
        checks++; if (timer_int !== 1'b0) begin failures++; $display("FAIL reset_timer_int got=%b exp=0", timer_int); end
        rst = 1'b0;
        tick();
        data_op(4'h0, 32'hBFAF_E004, 32'h0);
        checks++; if (data_sram_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_cmp got=%h exp=ffffffff", data_sram_rdata); end
        data_op(4'h0, 32'hBFAF_E000, 32'h0);
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_timer got=%h exp=0", data_sram_rdata); end
        data_op(4'h0, 32'hBFAF_E008, 32'h0);
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", data_sram_rdata); end
    endtask

    task automatic test_inst_read();
        data_op(4'hF, 32'h0000_0010, 32'h1234_5678);
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'h0000_0010;
        tick();
        inst_sram_en   = 1'b0;
        checks++; if (inst_sram_rdata !== 32'h1234_5678) begin failures++; $display("FAIL inst_read got=%h exp=12345678", inst_sram_rdata); end
        inst_sram_addr = 32'h0000_0040;
        tick();
        checks++; if (inst_sram_rdata !== 32'h1234_5678) begin failures++; $display("FAIL inst_hold got=%h exp=12345678", inst_sram_rdata); end
    endtask

    task automatic test_byte_lanes();
        data_op(4'hF, 32'h0000_0020, 32'h0);
        data_op(4'b0101, 32'h0000_0020, 32'hAABB_CCDD);
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL lane_rbw got=%h exp=0", data_sram_rdata); end
        data_op(4'h0, 32'h0000_0022, 32'h0);
        checks++; if (data_sram_rdata !== 32'h00BB_00DD) begin failures++; $display("FAIL lane_reread got=%h exp=00bb00dd", data_sram_rdata); end
    endtask

    task automatic test_same_edge();
        inst_sram_en    = 1'b1;
        inst_sram_addr  = 32'h0000_0020;
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'h0000_0020;
        data_sram_wdata = 32'hFFFF_FFFF;
        tick();
        inst_sram_en  = 1'b0;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'h0;
        checks++; if (inst_sram_rdata !== 32'h00BB_00DD) begin failures++; $display("FAIL same_edge_inst got=%h exp=00bb00dd", inst_sram_rdata); end
        checks++; if (data_sram_rdata !== 32'h00BB_00DD) begin failures++; $display("FAIL same_edge_data got=%h exp=00bb00dd", data_sram_rdata); end
        data_op(4'h0, 32'h0000_0020, 32'h0);
        checks++; if (data_sram_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL same_edge_after got=%h exp=ffffffff", data_sram_rdata); end
    endtask

    task automatic test_mmio();
        logic [31:0] n1, n2, exp_num;
        logic [7:0]  sw;
        data_op(4'hF, 32'hBFAF_F000, 32'h0001_ABCD);
        checks++; if (led !== 16'hABCD) begin failures++; $display("FAIL led_write got=%h exp=abcd", led); end
        data_op(4'h0, 32'hBFAF_F000, 32'h0);
        checks++; if (data_sram_rdata !== 32'h0000_ABCD) begin failures++; $display("FAIL led_read got=%h exp=0000abcd", data_sram_rdata); end
        data_op(4'b0010, 32'hBFAF_F000, 32'h0000_5500);
        checks++; if (led !== 16'h55CD) begin failures++; $display("FAIL led_lane got=%h exp=55cd", led); end
        n1 = $urandom;
        n2 = $urandom;
        exp_num = {n2[31:24], n1[23:0]};
        data_op(4'hF, 32'hBFAF_F010, n1);
        data_op(4'b1000, 32'hBFAF_F010, n2);
        checks++; if (num_data !== exp_num) begin failures++; $display("FAIL num_lane got=%h exp=%h", num_data, exp_num); end
        for (int k = 0; k < 2; k++) begin
            sw = (k == 0) ? 8'h5A : 8'($urandom);
            switch = sw;
            tick();
            tick();
            data_op(4'h0, 32'hBFAF_F020, 32'h0);
            checks++; if (data_sram_rdata !== {24'h0, sw}) begin failures++; $display("FAIL switch_read got=%h exp=%h", data_sram_rdata, {24'h0, sw}); end
        end
        data_op(4'hF, 32'hBFAF_F030, 32'hDEAD_BEEF);
        data_op(4'h0, 32'hBFAF_F030, 32'h0);
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=0", data_sram_rdata); end
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'hBFAF_F000;
        tick();
        inst_sram_en   = 1'b0;
        checks++; if (inst_sram_rdata !== 32'h0) begin failures++; $display("FAIL inst_mmio got=%h exp=0", inst_sram_rdata); end
    endtask

    task automatic test_timer();
        int          n;
        logic [31:0] c;
        c = 32'($urandom_range(3, 20));
        data_op(4'hF, 32'hBFAF_E004, c);
        data_op(4'hF, 32'hBFAF_E000, 32'h0);
        data_op(4'hF, 32'hBFAF_E008, 32'h1);
        // Counter starts at 0 after the enable edge; a match at value c is seen
        // c+1 edges later and PEND follows one edge after that.
        n = 0;
        while (!timer_int && n < 100) begin
            tick();
            n++;
        end
        checks++; if (n !== int'(c) + 2) begin failures++; $display("FAIL timer_rise got=%0d exp=%0d", n, int'(c) + 2); end
        data_op(4'b0001, 32'hBFAF_E008, 32'h3);
        checks++; if (timer_int !== 1'b0) begin failures++; $display("FAIL timer_w1c got=%b exp=0", timer_int); end
        // Load the counter with c so that the match and the W1C land on one edge.
        data_op(4'hF, 32'hBFAF_E000, c);
        data_op(4'h0, 32'hBFAF_E000, 32'h0);
        checks++; if (data_sram_rdata !== c) begin failures++; $display("FAIL timer_wr_prio got=%h exp=%h", data_sram_rdata, c); end
        checks++; if (timer_int !== 1'b0) begin failures++; $display("FAIL timer_pre_match got=%b exp=0", timer_int); end
        data_op(4'b0001, 32'hBFAF_E008, 32'h3);
        checks++; if (timer_int !== 1'b1) begin failures++; $display("FAIL timer_set_beats_clr got=%b exp=1", timer_int); end
        checks++; if (data_sram_rdata !== 32'h1) begin failures++; $display("FAIL ctrl_rbw got=%h exp=1", data_sram_rdata); end
        data_op(4'h0, 32'hBFAF_E008, 32'h0);
        checks++; if (data_sram_rdata !== 32'h3) begin failures++; $display("FAIL ctrl_read got=%h exp=3", data_sram_rdata); end
        data_op(4'b0001, 32'hBFAF_E008, 32'h2);
        checks++; if (timer_int !== 1'b0) begin failures++; $display("FAIL timer_disable got=%b exp=0", timer_int); end
        // wrap
        data_op(4'hF, 32'hBFAF_E000, 32'hFFFF_FFFE);
        data_op(4'b0001, 32'hBFAF_E008, 32'h1);
        tick();
        tick();
        data_op(4'h0, 32'hBFAF_E000, 32'h0);
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL timer_wrap got=%h exp=0", data_sram_rdata); end
        data_op(4'b0001, 32'hBFAF_E008, 32'h2);
    endtask

    task automatic test_random_ram();
        int          keys [32];
        int          di, ii;
        logic [3:0]  w;
        logic [31:0] v, exp_d, exp_i;
        // Indices 0..15 are kept for the directed words.
        for (int k = 0; k < 32; k++) begin
            keys[k] = $urandom_range(16, 16383);
            v = $urandom;
            data_op(4'hF, {16'($urandom_range(0, 16'h7FFF)), keys[k][13:0], 2'($urandom)}, v);
            ref_mem[keys[k]] = v;
        end
        for (int k = 0; k < 80; k++) begin
            di = keys[$urandom_range(0, 31)];
            ii = keys[$urandom_range(0, 31)];
            if (k % 5 == 0) ii = di;
            w  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            v  = $urandom;
            inst_sram_en    = 1'b1;
            inst_sram_addr  = {16'($urandom_range(0, 16'h7FFF)), ii[13:0], 2'($urandom)};
            data_sram_en    = 1'b1;
            data_sram_wen   = w;
            data_sram_addr  = {16'($urandom_range(0, 16'h7FFF)), di[13:0], 2'($urandom)};
            data_sram_wdata = v;
            tick();
            inst_sram_en  = 1'b0;
            data_sram_en  = 1'b0;
            data_sram_wen = 4'h0;
            exp_d = ref_mem[di];
            exp_i = ref_mem[ii];
            checks++; if (data_sram_rdata !== exp_d) begin failures++; $display("FAIL rand_data op=%0d got=%h exp=%h", k, data_sram_rdata, exp_d); end
            checks++; if (inst_sram_rdata !== exp_i) begin failures++; $display("FAIL rand_inst op=%0d got=%h exp=%h", k, inst_sram_rdata, exp_i); end
            ref_mem[di] = merge(ref_mem[di], v, w);
        end
    endtask

    task automatic test_async_reset();
        data_op(4'hF, 32'hBFAF_F000, 32'h0000_FFFF);
        data_op(4'h0, 32'h0000_0010, 32'h0);
        inst_sram_en   = 1'b1;
        inst_sram_addr = 32'h0000_0010;
        data_sram_en   = 1'b1;
        data_sram_addr = 32'h0000_0010;
        #3;
        rst = 1'b1;
        #1;
        checks++; if (inst_sram_rdata !== 32'h0) begin failures++; $display("FAIL arst_inst got=%h exp=0", inst_sram_rdata); end
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL arst_data got=%h exp=0", data_sram_rdata); end
        checks++; if (led !== 16'h0) begin failures++; $display("FAIL arst_led got=%h exp=0", led); end
        checks++; if (num_data !== 32'h0) begin failures++; $display("FAIL arst_num got=%h exp=0", num_data); end
        checks++; if (timer_int !== 1'b0) begin failures++; $display("FAIL arst_timer_int got=%b exp=0", timer_int); end
        tick();
        rst          = 1'b0;
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
        tick();
        checks++; if (data_sram_rdata !== 32'h0) begin failures++; $display("FAIL arst_discard_data got=%h exp=0", data_sram_rdata); end
        checks++; if (inst_sram_rdata !== 32'h0) begin failures++; $display("FAIL arst_discard_inst got=%h exp=0", inst_sram_rdata); end
        data_op(4'h0, 32'h0000_0010, 32'h0);
        checks++; if (data_sram_rdata !== 32'h1234_5678) begin failures++; $display("FAIL arst_ram_kept got=%h exp=12345678", data_sram_rdata); end
        data_op(4'h0, 32'hBFAF_E004, 32'h0);
        checks++; if (data_sram_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL arst_cmp got=%h exp=ffffffff", data_sram_rdata); end
    endtask

    initial begin
        rst             = 1'b1;
        inst_sram_en    = 1'b0;
        inst_sram_wen   = 4'h0;
        inst_sram_addr  = 32'h0;
        inst_sram_wdata = 32'h0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        switch          = 8'h0;
        test_reset();
        test_inst_read();
        test_byte_lanes();
        test_same_edge();
        test_mmio();
        test_timer();
        test_random_ram();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
